muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage.
- Replaces the fixed 32-bit divider start/success handshake with one sequential engine that handles MULT/MULTU, DIV/DIVU and, optionally, MADD/MSUB.
- Produces a 2*WIDTH result on {hi_o, lo_o} for the HI/LO write path.
- Drives a stall request to the pipeline controller while an operation is in flight.

Parameters:
- WIDTH, 32: operand width in bits; results are 2*WIDTH bits (HI, LO); must be >= 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request an operation; EX holds it high until done_o.
- cancel_i  in  1  flush (exception or branch squash); aborts any operation.
- op_i  in  2  00 MUL, 01 DIV, 10 MADD, 11 MSUB.
- signed_i  in  1  1 = signed operands.
- opa_i  in  WIDTH  multiplicand / dividend.
- opb_i  in  WIDTH  multiplier / divisor.
- acc_hi_i  in  WIDTH  current HI, used by MADD/MSUB.
- acc_lo_i  in  WIDTH  current LO, used by MADD/MSUB.
- ready_o  out  1  unit idle; start_i is accepted.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle result-valid pulse.
- hi_o  out  WIDTH  remainder (DIV) or upper product.
- lo_o  out  WIDTH  quotient (DIV) or lower product.
- dbz_o  out  1  last DIV had a zero divisor; valid with done_o.
- pause_o  out  1  combinational stall request to the pipeline.

Behaviour:
- Reset: state IDLE; ready_o=1; busy_o=0; done_o=0; dbz_o=0; hi_o=0; lo_o=0; counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY: on an edge with start_i=1 and cancel_i=0.
  - Operands are captured as magnitudes when signed_i=1.
  - Result signs are recorded: quotient/product sign = signA xor signB; remainder sign = signA.
  - Counter loads WIDTH.
- IDLE to DONE (zero divisor): DIV with opb_i=0 goes directly to DONE.
  - hi_o=opa_i, lo_o=all ones, dbz_o=1.
  - Latency 1 edge.
- BUSY: one iteration per edge; counter decrements.
  - MUL: shift-add, 1 bit per edge.
  - DIV: restoring, 1 quotient bit per edge.
- BUSY to DONE: on the edge where counter reaches 0, i.e. WIDTH edges after the start edge.
  - Sign correction (two's-complement negate) and accumulation are applied in that same registering edge.
  - hi_o/lo_o/dbz_o are updated there.
- DONE to IDLE: unconditionally on the next edge; done_o=1 only while in DONE.
  - start_i is ignored in DONE; the earliest next accept is the edge after DONE.
- ready_o = (state==IDLE); busy_o = (state==BUSY).
- pause_o = busy_o | (ready_o & start_i & ~cancel_i). It is 0 in DONE so EX advances with the result.
- start_i while in BUSY: ignored; captured operands are not resampled.
- cancel_i: in any state returns to IDLE on the next edge.
  - No done_o; hi_o/lo_o/dbz_o keep their previous values.
  - cancel_i outranks start_i in the same cycle.
- Signed overflow: MIN/-1 gives lo_o=MIN, hi_o=0, with no trap.
- Unsigned MUL: full 2*WIDTH product, no truncation.
- hi_o/lo_o hold their value until the next DONE entry or reset.
- Reset mid-operation: immediate return to reset values on that edge.

Optional Feature:
- Macro: MULDIV_ACC_EN.
- Defined:
  - op 10 (MADD): {hi_o,lo_o} = {acc_hi_i,acc_lo_i} + product.
  - op 11 (MSUB): {hi_o,lo_o} = {acc_hi_i,acc_lo_i} - product.
  - Arithmetic is modulo 2^(2*WIDTH); the accumulator is sampled on the start edge; latency is unchanged.
- Not defined: op 10/11 execute as plain MUL; acc_hi_i/acc_lo_i are unused.

Test Plan:
- DIVU 100/7, WIDTH=32 -> done_o exactly 32 edges after the start edge; lo_o=14, hi_o=2, dbz_o=0; pause_o high from start until done.
- DIV signed -7/2 (0xFFFFFFF9, 2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; MIN/-1 (0x80000000, 0xFFFFFFFF) -> lo_o=0x80000000, hi_o=0.
- MULT 0xFFFFFFFF*2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE; MULTU same operands -> hi_o=1, lo_o=0xFFFFFFFE.
- DIV 5/0 -> done_o 1 edge after start; hi_o=5, lo_o=0xFFFFFFFF, dbz_o=1.
- Start DIV, then cancel_i at BUSY edge 10 -> IDLE next edge, no done_o, hi_o/lo_o unchanged. Also: start_i held through DONE -> no re-trigger; accepted the edge after DONE. Also: rst mid-BUSY -> all outputs 0.
- With MULDIV_ACC_EN: MADD acc={1,0}, 3*4 -> hi_o=1, lo_o=12. MSUB acc={0,0}, 1*1 -> hi_o=lo_o=0xFFFFFFFF. Without the macro, MADD 3*4 -> hi_o=0, lo_o=12.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Handshake and operand/result bundle between the EX stage and the
// iterative multiply/divide unit. The EX side drives the master modport,
// the unit sits on the slave modport.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             cancel_i;
  logic [1:0]       op_i;
  logic             signed_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic [WIDTH-1:0] acc_hi_i;
  logic [WIDTH-1:0] acc_lo_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dbz_o;
  logic             pause_o;

  modport master (
    output start_i, cancel_i, op_i, signed_i, opa_i, opb_i, acc_hi_i, acc_lo_i,
    input  ready_o, busy_o, done_o, hi_o, lo_o, dbz_o, pause_o
  );

  modport slave (
    input  start_i, cancel_i, op_i, signed_i, opa_i, opb_i, acc_hi_i, acc_lo_i,
    output ready_o, busy_o, done_o, hi_o, lo_o, dbz_o, pause_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the EX stage.
// One sequential engine: shift-add MUL (1 bit/edge), restoring DIV
// (1 quotient bit/edge). Signed operands are processed as magnitudes and
// the result is sign-corrected on the final registering edge.
// Optional MADD/MSUB accumulation is enabled by defining MULDIV_ACC_EN;
// without it op 10/11 run as plain MUL and acc_hi_i/acc_lo_i are ignored.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_iter_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // p: {remainder, quotient} for DIV, {partial product, multiplier} for MUL
  logic [W2-1:0]    p_q, p_d;
  // m: divisor magnitude (DIV) or multiplicand magnitude (MUL)
  logic [WIDTH-1:0] m_q, m_d;
  logic             div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
`ifdef MULDIV_ACC_EN
  logic [W2-1:0]    acc_q, acc_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_sub_q, acc_sub_d;
`else
  logic             unused_acc;
  assign unused_acc = ^{bus.acc_hi_i, bus.acc_lo_i};
`endif

  // Operand decode and magnitude capture
  logic             in_div, sa, sb, zdiv;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign in_div = (bus.op_i == 2'b01);
  assign sa     = bus.signed_i & bus.opa_i[WIDTH-1];
  assign sb     = bus.signed_i & bus.opb_i[WIDTH-1];
  assign mag_a  = sa ? (~bus.opa_i + 1'b1) : bus.opa_i;
  assign mag_b  = sb ? (~bus.opb_i + 1'b1) : bus.opb_i;
  assign zdiv   = in_div & (bus.opb_i == '0);

  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [W2-1:0]    p_step, prod, prod_acc, result;
  logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;

  // One iteration of the engine plus the final sign fix / accumulation
  always_comb begin
    mul_sum  = {1'b0, p_q[W2-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    rem_sh   = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, m_q};
    if (div_q) begin
      // borrow means the trial subtraction failed: restore, quotient bit 0
      p_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0],   p_q[WIDTH-2:0], 1'b0}
                               : {rem_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_step = {mul_sum, p_q[WIDTH-1:1]};
    end
    quo     = p_step[WIDTH-1:0];
    rem     = p_step[W2-1:WIDTH];
    quo_fix = qneg_q ? (~quo + 1'b1) : quo;
    rem_fix = rneg_q ? (~rem + 1'b1) : rem;
    prod    = qneg_q ? (~p_step + 1'b1) : p_step;
`ifdef MULDIV_ACC_EN
    if (acc_en_q) prod_acc = acc_sub_q ? (acc_q - prod) : (acc_q + prod);
    else          prod_acc = prod;
`else
    prod_acc = prod;
`endif
    result = div_q ? {rem_fix, quo_fix} : prod_acc;
  end

  // Next-state logic: FSM transitions, operand capture, result registering
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    m_d       = m_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
`ifdef MULDIV_ACC_EN
    acc_d     = acc_q;
    acc_en_d  = acc_en_q;
    acc_sub_d = acc_sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (zdiv) begin
            // zero divisor short-circuits straight to DONE
            state_d = DONE;
            hi_d    = bus.opa_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WIDTH);
            div_d   = in_div;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            p_d     = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            m_d     = in_div ? mag_b : mag_a;
`ifdef MULDIV_ACC_EN
            acc_d     = {bus.acc_hi_i, bus.acc_lo_i};
            acc_en_d  = bus.op_i[1];
            acc_sub_d = bus.op_i[0];
`endif
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        p_d   = p_step;
        if (cnt_q == CNT_W'(1)) begin
          state_d      = DONE;
          {hi_d, lo_d} = result;
          dbz_d        = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // flush wins over everything; results keep their last values
    if (bus.cancel_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      m_q       <= '0;
      div_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
`ifdef MULDIV_ACC_EN
      acc_q     <= '0;
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      m_q       <= m_d;
      div_q     <= div_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
`ifdef MULDIV_ACC_EN
      acc_q     <= acc_d;
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
`endif
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.busy_o  = (state_q == BUSY);
  assign bus.done_o  = (state_q == DONE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.dbz_o   = dbz_q;
  // stall EX from the request cycle through the last BUSY cycle
  assign bus.pause_o = bus.busy_o | (bus.ready_o & bus.start_i & ~bus.cancel_i);
endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (WIDTH=32): directed cases followed by
// random operations compared against a plain-arithmetic reference model.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  logic         last_dbz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact 64-bit arithmetic straight from the operation definitions
  function automatic void model(input logic [1:0] op, input logic sg,
                                input logic [W-1:0] a, b, ah, al,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dbz);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    dbz = 1'b0;
    if (op == 2'b01) begin
      if (b == '0) begin
        hi = a; lo = '1; dbz = 1'b1;
      end else begin
        if (sg) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
        end else begin
          sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
    end else begin
      if (sg) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else    p = {32'b0, a} * {32'b0, b};
      acc = {ah, al};
`ifdef MULDIV_ACC_EN
      if (op == 2'b10)      p = acc + p;
      else if (op == 2'b11) p = acc - p;
`endif
      if (acc == 64'hFFFF_FFFF_FFFF_FFFF && op == 2'b00) p = p; // acc ignored for plain MUL
      {hi, lo} = p;
    end
  endfunction

  task automatic start_op(input logic [1:0] op, input logic sg,
                          input logic [W-1:0] a, b, ah, al);
    bus.op_i = op; bus.signed_i = sg; bus.opa_i = a; bus.opb_i = b;
    bus.acc_hi_i = ah; bus.acc_lo_i = al;
    bus.start_i = 1'b1;
    #1;
  endtask

  // Counts edges from the accepting edge (inclusive) until done_o is seen:
  // WIDTH+1 for a normal operation, 1 for a zero-divisor DIV.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [W-1:0] eh, el, input logic edbz, input bit hold);
    int n = 0;
    bit pause_ok = 1'b1;
    do begin
      if (bus.pause_o !== 1'b1) pause_ok = 1'b0;
      step();
      n++;
    end while (bus.done_o !== 1'b1 && n < 200);
    chk({tag, ".pause_inflight"}, 64'(pause_ok), 64'd1);
    chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
    chk({tag, ".hi"}, 64'(bus.hi_o), 64'(eh));
    chk({tag, ".lo"}, 64'(bus.lo_o), 64'(el));
    chk({tag, ".dbz"}, 64'(bus.dbz_o), 64'(edbz));
    chk({tag, ".pause_done"}, 64'(bus.pause_o), 64'd0);
    last_hi = eh; last_lo = el; last_dbz = edbz;
    if (!hold) begin
      bus.start_i = 1'b0;
      step();
      chk({tag, ".ready_after"}, 64'(bus.ready_o), 64'd1);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic sg,
                     input logic [W-1:0] a, b, ah, al);
    logic [W-1:0] eh, el;
    logic edbz;
    model(op, sg, a, b, ah, al, eh, el, edbz);
    start_op(op, sg, a, b, ah, al);
    wait_done(tag, edbz ? 1 : W + 1, eh, el, edbz, 1'b0);
  endtask

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic edbz;
    logic [1:0] rop;
    bit seen;

    bus.start_i = 1'b0; bus.cancel_i = 1'b0; bus.op_i = 2'b00; bus.signed_i = 1'b0;
    bus.opa_i = '0; bus.opb_i = '0; bus.acc_hi_i = '0; bus.acc_lo_i = '0;

    // reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst.ready", 64'(bus.ready_o), 64'd1);
    chk("rst.busy",  64'(bus.busy_o),  64'd0);
    chk("rst.done",  64'(bus.done_o),  64'd0);
    chk("rst.dbz",   64'(bus.dbz_o),   64'd0);
    chk("rst.hi",    64'(bus.hi_o),    64'd0);
    chk("rst.lo",    64'(bus.lo_o),    64'd0);
    chk("rst.pause", 64'(bus.pause_o), 64'd0);

    // directed arithmetic cases
    run("divu_100_7", 2'b01, 1'b0, 32'd100, 32'd7, '0, '0);
    chk("divu_100_7.lo_const", 64'(last_lo), 64'd14);
    run("div_m7_2",   2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, '0, '0);
    chk("div_m7_2.lo_const", 64'(last_lo), 64'hFFFF_FFFD);
    run("div_min_m1", 2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
    run("mult_m1_2",  2'b00, 1'b1, 32'hFFFF_FFFF, 32'd2, '0, '0);
    run("multu_ff_2", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, '0, '0);
    run("div_5_0",    2'b01, 1'b0, 32'd5, 32'd0, '0, '0);
    run("madd_3_4",   2'b10, 1'b0, 32'd3, 32'd4, 32'd1, 32'd0);
    run("msub_1_1",   2'b11, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);

    // cancel outranks start in IDLE
    start_op(2'b00, 1'b0, 32'd9, 32'd9, '0, '0);
    bus.cancel_i = 1'b1;
    #1;
    chk("cancel_idle.pause", 64'(bus.pause_o), 64'd0);
    step();
    chk("cancel_idle.ready", 64'(bus.ready_o), 64'd1);
    bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    step();

    // cancel at BUSY edge 10: no done, results unchanged
    start_op(2'b01, 1'b0, 32'd1000, 32'd3, '0, '0);
    for (int i = 0; i < 10; i++) step();
    chk("cancel_busy.busy", 64'(bus.busy_o), 64'd1);
    bus.cancel_i = 1'b1;
    step();
    bus.cancel_i = 1'b0; bus.start_i = 1'b0;
    #1;
    chk("cancel_busy.ready", 64'(bus.ready_o), 64'd1);
    chk("cancel_busy.done",  64'(bus.done_o),  64'd0);
    chk("cancel_busy.hi",    64'(bus.hi_o),    64'(last_hi));
    chk("cancel_busy.lo",    64'(bus.lo_o),    64'(last_lo));
    chk("cancel_busy.dbz",   64'(bus.dbz_o),   64'(last_dbz));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done_o === 1'b1) seen = 1'b1;
    end
    chk("cancel_busy.no_done", 64'(seen), 64'd0);

    // start held through DONE: no re-trigger, accepted the edge after DONE
    model(2'b00, 1'b0, 32'd6, 32'd7, '0, '0, eh, el, edbz);
    start_op(2'b00, 1'b0, 32'd6, 32'd7, '0, '0);
    wait_done("hold1", W + 1, eh, el, edbz, 1'b1);
    step();
    chk("hold.ready", 64'(bus.ready_o), 64'd1);
    chk("hold.done",  64'(bus.done_o),  64'd0);
    chk("hold.busy",  64'(bus.busy_o),  64'd0);
    wait_done("hold2", W + 1, eh, el, edbz, 1'b0);

    // reset in the middle of BUSY
    start_op(2'b00, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, '0, '0);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; bus.start_i = 1'b0;
    step();
    chk("rst_busy.ready", 64'(bus.ready_o), 64'd1);
    chk("rst_busy.busy",  64'(bus.busy_o),  64'd0);
    chk("rst_busy.done",  64'(bus.done_o),  64'd0);
    chk("rst_busy.hi",    64'(bus.hi_o),    64'd0);
    chk("rst_busy.lo",    64'(bus.lo_o),    64'd0);
    chk("rst_busy.dbz",   64'(bus.dbz_o),   64'd0);
    rst = 1'b0;
    step();

    // random operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run($sformatf("rand%0d", i), rop, 1'($urandom_range(0, 1)), ra, rb, $urandom(), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
